// File: rtl/tri_pkg.sv
// Shared types and constants for the triangular-solve diagonal feeder.
// fp_is_zero treats +0.0 and -0.0 alike by ignoring the sign bit.
package tri_pkg;

    localparam int DWIDTH = 32;
    localparam int N      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic fp_is_zero(input logic [DWIDTH-1:0] w);
        return (w[DWIDTH-2:0] == '0);
    endfunction

endpackage

// File: rtl/tri_diag_regfile.sv
// Diagonal storage: DEPTH x WIDTH flops, one synchronous write port, one
// combinational read port, cleared by reset.
module tri_diag_regfile
    import tri_pkg::*;
#(
    parameter int WIDTH  = DWIDTH,
    parameter int DEPTH  = N,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: this is a flop array, not a RAM macro, so clearing every entry on
    // reset is legal; a true RAM could not be reset in a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tri_diag_feeder.sv
// Head of the triangular array: issues x[k]/diag[k] to the circle PE and returns
// z[k] on a valid/ready stream, with at most one divide outstanding.
module tri_diag_feeder
    import tri_pkg::state_e, tri_pkg::IDLE, tri_pkg::RUN, tri_pkg::fp_is_zero;
#(
    parameter int DWIDTH = tri_pkg::DWIDTH,
    parameter int N      = tri_pkg::N,
    localparam int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              diag_wr_en,
    input  logic [IDX_W-1:0]  diag_wr_addr,
    input  logic [DWIDTH-1:0] diag_wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_zero,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              pe_en,
    output logic [DWIDTH-1:0] pe_xin,
    output logic [DWIDTH-1:0] pe_cir_x,
    input  logic [DWIDTH-1:0] pe_zout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx
);

    localparam int CNT_W = IDX_W + 1;

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    issued;
    logic [IDX_W-1:0]    k;
    logic                pend;
    logic [IDX_W-1:0]    tag;
    logic [DWIDTH-1:0]   xin_q, cir_q, diag_rd;
    logic                accept, out_fire, last_fire;
    logic                done_q, err_q;

    assign k = issued[IDX_W-1:0];

    tri_diag_regfile #(.WIDTH(DWIDTH), .DEPTH(N)) u_diag (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (diag_wr_en && (state == IDLE)),
        .wr_addr (diag_wr_addr),
        .wr_data (diag_wr_data),
        .rd_addr (k),
        .rd_data (diag_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !pend && (issued < CNT_W'(N)) && (!out_valid || out_ready);
                if (last_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && (out_idx == IDX_W'(N - 1));

    // The PE sees the live operands on the issue cycle and the last ones otherwise.
    assign pe_en    = accept;
    assign pe_xin   = accept ? in_data : xin_q;
    assign pe_cir_x = accept ? diag_rd : cir_q;
    assign done     = done_q;
    assign err_zero = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued    <= '0;
            pend      <= 1'b0;
            tag       <= '0;
            xin_q     <= '0;
            cir_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= (state == RUN) && last_fire;
            pend   <= accept;
            if ((state == IDLE) && start) begin
                issued <= '0;
                err_q  <= 1'b0;
            end
            if (accept) begin
                tag    <= k;
                issued <= issued + CNT_W'(1);
                xin_q  <= in_data;
                cir_q  <= diag_rd;
                if (fp_is_zero(diag_rd)) err_q <= 1'b1;
            end
            // The PE quotient is registered, so it is captured one cycle after issue.
            if (pend) begin
                out_valid <= 1'b1;
                out_data  <= pe_zout;
                out_idx   <= tag;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tri_diag_feeder.sv
// Self-checking bench for tri_diag_feeder with a behavioural fp32 circle PE
// on the pe_* ports and a per-solve scoreboard of expected quotients.
module tb_tri_diag_feeder;

    localparam int NN = tri_pkg::N;
    localparam int IW = $clog2(NN);

    logic          clk = 1'b0;
    logic          rst;
    logic          diag_wr_en;
    logic [IW-1:0] diag_wr_addr;
    logic [31:0]   diag_wr_data;
    logic          start;
    logic          busy, done, err_zero;
    logic          in_valid, in_ready;
    logic [31:0]   in_data;
    logic          pe_en;
    logic [31:0]   pe_xin, pe_cir_x, pe_zout;
    logic          out_valid, out_ready;
    logic [31:0]   out_data;
    logic [IW-1:0] out_idx;

    int checks = 0;
    int passed = 0;

    logic [31:0] diag_model [NN];
    logic [31:0] x_vec      [NN];
    logic [31:0] out_cap    [NN];
    logic [31:0] last_data;

    always #5 clk = ~clk;

    tri_diag_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .diag_wr_en   (diag_wr_en),
        .diag_wr_addr (diag_wr_addr),
        .diag_wr_data (diag_wr_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err_zero     (err_zero),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .pe_en        (pe_en),
        .pe_xin       (pe_xin),
        .pe_cir_x     (pe_cir_x),
        .pe_zout      (pe_zout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx)
    );

    // fp32 <-> real conversion (denormals flushed) for the PE and the model.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 2047)     return (d[51:0] != 0) ? {d[63], 8'hFF, 23'h400000} : {d[63], 8'hFF, 23'd0};
        else if (e >= 1151) return {d[63], 8'hFF, 23'd0};
        else if (e <= 896)  return {d[63], 31'd0};
        else                return {d[63], 8'(e - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) / f2r(b));
    endfunction

    // Circle PE: registered quotient, valid the cycle after pe_en.
    always @(posedge clk) begin
        if (pe_en) pe_zout <= fdiv(pe_xin, pe_cir_x);
    end

    task automatic load_diag();
        for (int i = 0; i < NN; i++) begin
            diag_wr_en   = 1'b1;
            diag_wr_addr = IW'(i);
            diag_wr_data = diag_model[i];
            @(posedge clk); #1;
        end
        diag_wr_en = 1'b0;
    endtask

    // Starts a solve, streams x_vec, scores every output against the model.
    task automatic run_solve(input string name, input bit rnd, input int stall_len,
                             input int poke, input int abort_after);
        int cyc, nx, got, dones, extra_dones;
        int pe_bad, err_bad, acc_bad, bp_bad, extra_bad, busy_bad, stall;
        bit first_seen, exp_err, prev_pe;
        logic [31:0]   held_d, exp_d;
        logic [IW-1:0] held_i;
        cyc = 0; nx = 0; got = 0; dones = 0; extra_dones = 0; stall = 0;
        pe_bad = 0; err_bad = 0; acc_bad = 0; bp_bad = 0; extra_bad = 0; busy_bad = 0;
        first_seen = 0; exp_err = 0; prev_pe = 0; held_d = '0; held_i = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (dones == 0 && cyc < 400) begin
            if (!first_seen && stall_len > 0 && out_valid === 1'b1) begin
                first_seen = 1; stall = stall_len; held_d = out_data; held_i = out_idx;
            end
            out_ready    = (stall > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_valid     = (nx < NN) ? (rnd ? ($urandom_range(0, 2) != 0) : 1'b1) : 1'b1;
            in_data      = (nx < NN) ? x_vec[nx] : $urandom();
            diag_wr_en   = (cyc == poke);
            start        = (cyc == poke);
            diag_wr_addr = '0;
            diag_wr_data = 32'h3F000000;
            #1;
            if (done === 1'b1) begin
                dones++;
                if (busy !== 1'b0) busy_bad++;
            end else if (busy !== 1'b1) busy_bad++;
            if (stall > 0) begin
                if (in_ready !== 1'b0 || pe_en !== 1'b0 || out_data !== held_d || out_idx !== held_i)
                    bp_bad++;
                stall--;
            end
            if (pe_en !== (in_valid && in_ready) || (pe_en && prev_pe)) pe_bad++;
            prev_pe = pe_en;
            if (err_zero !== exp_err) err_bad++;
            if (in_valid && in_ready) begin
                if (nx >= NN) extra_bad++;
                else begin
                    if (pe_xin !== x_vec[nx] || pe_cir_x !== diag_model[nx]) acc_bad++;
                    if (diag_model[nx][30:0] == 31'd0) exp_err = 1;
                    nx++;
                end
            end
            if (out_valid && out_ready) begin
                if (got >= NN) extra_bad++;
                else begin
                    exp_d = fdiv(x_vec[got], diag_model[got]);
                    checks++;
                    if (out_idx !== IW'(got)) $display("FAIL %s out_idx word %0d got=%0d exp=%0d", name, got, out_idx, got);
                    else passed++;
                    checks++;
                    if (out_data !== exp_d) $display("FAIL %s out_data idx %0d got=%h exp=%h", name, got, out_data, exp_d);
                    else passed++;
                    out_cap[got] = out_data;
                    last_data    = out_data;
                end
                got++;
            end
            if (abort_after > 0 && got >= abort_after) break;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0; diag_wr_en = 1'b0;
        if (abort_after > 0) begin
            checks++;
            if (got !== abort_after) $display("FAIL %s words before abort got=%0d exp=%0d", name, got, abort_after);
            else passed++;
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
                if (done === 1'b1) extra_dones++;
            end
            checks++;
            if (got !== NN) $display("FAIL %s word count got=%0d exp=%0d", name, got, NN);
            else passed++;
            checks++;
            if (dones + extra_dones !== 1) $display("FAIL %s done pulses got=%0d exp=1", name, dones + extra_dones);
            else passed++;
            checks++;
            if (busy_bad !== 0) $display("FAIL %s busy/done alignment errors got=%0d exp=0", name, busy_bad);
            else passed++;
            checks++;
            if (pe_bad !== 0) $display("FAIL %s pe_en pulse errors got=%0d exp=0", name, pe_bad);
            else passed++;
            checks++;
            if (acc_bad !== 0) $display("FAIL %s pe operand errors got=%0d exp=0", name, acc_bad);
            else passed++;
            checks++;
            if (err_bad !== 0) $display("FAIL %s err_zero timing errors got=%0d exp=0", name, err_bad);
            else passed++;
            checks++;
            if (extra_bad !== 0) $display("FAIL %s accepts/words beyond N got=%0d exp=0", name, extra_bad);
            else passed++;
            if (stall_len > 0) begin
                checks++;
                if (bp_bad !== 0) $display("FAIL %s stall hold errors got=%0d exp=0", name, bp_bad);
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)      $display("FAIL reset busy got=%b exp=0", busy);           else passed++;
        checks++; if (done !== 1'b0)      $display("FAIL reset done got=%b exp=0", done);           else passed++;
        checks++; if (err_zero !== 1'b0)  $display("FAIL reset err_zero got=%b exp=0", err_zero);   else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (out_data !== 32'd0) $display("FAIL reset out_data got=%h exp=0", out_data);   else passed++;
        checks++; if (pe_en !== 1'b0)     $display("FAIL reset pe_en got=%b exp=0", pe_en);         else passed++;
        checks++; if (in_ready !== 1'b0)  $display("FAIL reset in_ready got=%b exp=0", in_ready);   else passed++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < NN; i++) begin diag_model[i] = 32'h40000000; x_vec[i] = 32'h41000000; end
        load_diag();
        run_solve("basic", 1'b0, 0, -1, 0);
        checks++;
        if (last_data !== 32'h40800000) $display("FAIL basic last quotient got=%h exp=40800000", last_data);
        else passed++;
    endtask

    task automatic test_per_index();
        for (int i = 0; i < NN; i++) begin diag_model[i] = 32'h3F800000; x_vec[i] = 32'h3F800000; end
        diag_model[3] = 32'h40400000;
        x_vec[3]      = 32'h40C00000;
        load_diag();
        run_solve("per_index", 1'b0, 0, -1, 0);
        checks++;
        if (out_cap[3] !== 32'h40000000) $display("FAIL per_index out[3] got=%h exp=40000000", out_cap[3]);
        else passed++;
        checks++;
        if (out_cap[4] !== 32'h3F800000) $display("FAIL per_index out[4] got=%h exp=3f800000", out_cap[4]);
        else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NN; i++) begin
            diag_model[i] = r2f(real'($urandom_range(1, 9)));
            x_vec[i]      = r2f(real'($urandom_range(0, 99)));
        end
        load_diag();
        run_solve("backpressure", 1'b0, 5, -1, 0);
    endtask

    task automatic test_zero_diag();
        for (int i = 0; i < NN; i++) begin diag_model[i] = 32'h40000000; x_vec[i] = r2f(real'($urandom_range(1, 50))); end
        diag_model[2] = 32'h80000000;
        load_diag();
        run_solve("zero_diag", 1'b0, 0, -1, 0);
        checks++;
        if (err_zero !== 1'b1) $display("FAIL zero_diag err_zero after done got=%b exp=1", err_zero);
        else passed++;
        diag_model[2] = 32'h40800000;
        load_diag();
        run_solve("zero_diag_clear", 1'b0, 0, -1, 0);
        checks++;
        if (err_zero !== 1'b0) $display("FAIL zero_diag err_zero after restart got=%b exp=0", err_zero);
        else passed++;
    endtask

    task automatic test_ignored_controls();
        for (int i = 0; i < NN; i++) begin diag_model[i] = r2f(real'($urandom_range(1, 8))); x_vec[i] = r2f(real'($urandom_range(1, 64))); end
        load_diag();
        run_solve("ignored_ctrl", 1'b0, 0, 4, 0);
        run_solve("ignored_ctrl_verify", 1'b0, 0, -1, 0);
    endtask

    task automatic test_midsolve_reset();
        for (int i = 0; i < NN; i++) begin diag_model[i] = r2f(real'($urandom_range(1, 8))); x_vec[i] = r2f(real'($urandom_range(1, 64))); end
        load_diag();
        run_solve("mid_reset", 1'b0, 0, -1, 3);
        rst       = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)      $display("FAIL mid_reset busy got=%b exp=0", busy);           else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (out_data !== 32'd0) $display("FAIL mid_reset out_data got=%h exp=0", out_data);   else passed++;
        checks++; if (out_idx !== '0)     $display("FAIL mid_reset out_idx got=%0d exp=0", out_idx);    else passed++;
        checks++; if (in_ready !== 1'b0)  $display("FAIL mid_reset in_ready got=%b exp=0", in_ready);   else passed++;
        checks++; if (pe_en !== 1'b0)     $display("FAIL mid_reset pe_en got=%b exp=0", pe_en);         else passed++;
        checks++; if (done !== 1'b0)      $display("FAIL mid_reset done got=%b exp=0", done);           else passed++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Diagonal was wiped: every divisor is now +0.0.
        for (int i = 0; i < NN; i++) diag_model[i] = 32'd0;
        run_solve("post_reset", 1'b0, 0, -1, 0);
        checks++;
        if (err_zero !== 1'b1) $display("FAIL post_reset err_zero got=%b exp=1", err_zero);
        else passed++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NN; i++) begin
                diag_model[i] = r2f(real'($urandom_range(1, 16)) * (($urandom_range(0, 1) != 0) ? -1.0 : 1.0));
                x_vec[i]      = r2f(real'($urandom_range(0, 1000)) / 8.0);
            end
            load_diag();
            run_solve("random", 1'b1, (s == 1) ? 3 : 0, -1, 0);
        end
    endtask

    initial begin
        rst = 1'b1; diag_wr_en = 1'b0; diag_wr_addr = '0; diag_wr_data = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; last_data = '0;
        for (int i = 0; i < NN; i++) out_cap[i] = '0;
        test_reset();
        test_basic();
        test_per_index();
        test_backpressure();
        test_zero_diag();
        test_ignored_controls();
        test_midsolve_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
